// File: rtl/vx_writeback_arb.sv
// N-to-1 writeback arbiter: round-robin between packets, locked to one source
// from sop to eop, single registered output stage with valid/ready.

module vx_writeback_arb_lane #(
  parameter int SEL_W = 2,
  parameter int LANE  = 0
) (
  input  logic             reset,
  input  logic             grant_vld,
  input  logic [SEL_W-1:0] grant_idx,
  input  logic             adv,
  output logic             ready
);
  // Held low in reset so no upstream beat is consumed while state is cleared.
  assign ready = reset && adv && grant_vld && (grant_idx == SEL_W'(LANE));
endmodule

module vx_writeback_arb #(
  parameter int NUM_INPUTS = 4,
  parameter int DATAW      = 256,
  parameter int SEL_W      = (NUM_INPUTS > 1) ? $clog2(NUM_INPUTS) : 1
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic [NUM_INPUTS-1:0]             in_valid,
  input  logic [NUM_INPUTS-1:0]             in_sop,
  input  logic [NUM_INPUTS-1:0]             in_eop,
  input  logic [NUM_INPUTS-1:0][DATAW-1:0]  in_data,
  output logic [NUM_INPUTS-1:0]             in_ready,
  output logic                              out_valid,
  output logic                              out_sop,
  output logic                              out_eop,
  output logic [DATAW-1:0]                  out_data,
  output logic [SEL_W-1:0]                  out_sel,
  input  logic                              out_ready,
  output logic                              locked,
  output logic                              proto_err
);

  typedef enum logic {IDLE = 1'b0, LOCKED = 1'b1} lock_e;

  typedef struct packed {
    logic             sop;
    logic             eop;
    logic [SEL_W-1:0] sel;
    logic [DATAW-1:0] data;
  } beat_t;

  lock_e            lock_q, lock_d;
  logic [SEL_W-1:0] owner_q, rr_ptr_q;
  logic [SEL_W-1:0] grant_idx, cand;
  logic             grant_vld, adv, acc;
  logic             out_vld_q, err_q;
  beat_t            out_q, in_beat;

  // Increment modulo NUM_INPUTS; the extra bit avoids overflow before the wrap test.
  function automatic logic [SEL_W-1:0] wrap_inc(input logic [SEL_W-1:0] v);
    logic [SEL_W:0] s;
    s = {1'b0, v} + (SEL_W+1)'(1);
    if (s >= (SEL_W+1)'(NUM_INPUTS)) s = '0;
    return s[SEL_W-1:0];
  endfunction

  assign adv = !out_vld_q || out_ready;

  always_comb begin
    grant_vld = 1'b0;
    grant_idx = rr_ptr_q;
    cand      = rr_ptr_q;
    if (lock_q == LOCKED) begin
      grant_vld = in_valid[owner_q];
      grant_idx = owner_q;
    end else begin
      for (int k = 0; k < NUM_INPUTS; k++) begin
        if (!grant_vld && in_valid[cand]) begin
          grant_vld = 1'b1;
          grant_idx = cand;
        end
        cand = wrap_inc(cand);
      end
    end
  end

  assign acc = reset && grant_vld && adv;

  always_comb begin
    in_beat.sop  = in_sop[grant_idx];
    in_beat.eop  = in_eop[grant_idx];
    in_beat.sel  = grant_idx;
    in_beat.data = in_data[grant_idx];
  end

  genvar gi;
  generate
    for (gi = 0; gi < NUM_INPUTS; gi++) begin : g_lane
      vx_writeback_arb_lane #(.SEL_W(SEL_W), .LANE(gi)) u_lane (
        .reset     (reset),
        .grant_vld (grant_vld),
        .grant_idx (grant_idx),
        .adv       (adv),
        .ready     (in_ready[gi])
      );
    end
  endgenerate

  // Lock FSM: state register
  always_ff @(posedge clk) begin
    if (!reset) lock_q <= IDLE;
    else        lock_q <= lock_d;
  end

  // Lock FSM: next state. A stray sop inside a packet keeps the lock.
  always_comb begin
    lock_d = lock_q;
    if (acc) begin
      if (in_beat.eop)      lock_d = IDLE;
      else if (in_beat.sop) lock_d = LOCKED;
    end
  end

  // Lock FSM: outputs
  always_comb begin
    locked = (lock_q == LOCKED);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      owner_q   <= '0;
      rr_ptr_q  <= '0;
      err_q     <= 1'b0;
      out_vld_q <= 1'b0;
      out_q     <= '0;
    end else begin
      if (acc && in_beat.sop && !in_beat.eop) owner_q <= grant_idx;
      if (acc && in_beat.eop) rr_ptr_q <= wrap_inc(grant_idx);
      // Error when sop disagrees with lock state: missing sop in IDLE, extra sop in LOCKED.
      if (acc && ((lock_q == LOCKED) == in_beat.sop)) err_q <= 1'b1;
      if (adv) begin
        out_vld_q <= acc;
        if (acc) out_q <= in_beat;
      end
    end
  end

  assign out_valid = out_vld_q;
  assign out_sop   = out_q.sop;
  assign out_eop   = out_q.eop;
  assign out_sel   = out_q.sel;
  assign out_data  = out_q.data;
  assign proto_err = err_q;

endmodule
